// File: rtl/dingshi_sched.sv
// dingshi_sched: round-robin arbiter lending one shared countdown timer to N_REQ requesters
module dingshi_sched #(
  parameter int N_REQ  = 4,
  parameter int RW     = 4,
  parameter int WD_MAX = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*RW-1:0]   i_reps,
  input  logic                  i_tmr_expired,
  output logic                  o_tmr_open,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [N_REQ-1:0]      o_done,
  output logic                  o_aborted,
  output logic                  o_busy,
  output logic                  o_fault
);
  localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IW1 = IW + 1;
  localparam logic [7:0] WD_LAST = 8'(WD_MAX - 1);
  typedef enum logic [1:0] {IDLE, RUN, RELOAD, DONE} state_t;
  state_t r_state, w_state_nx;
  logic [N_REQ-1:0] r_gnt, w_gnt_nx, r_done, w_done_nx;
  logic [IW-1:0] r_ptr, w_ptr_nx, r_own, w_own_nx, w_off, w_pick, w_own_inc;
  logic [IW1-1:0] w_sum;
  logic [RW-1:0] r_rep, w_rep_nx, w_slice;
  logic [7:0] r_wd, w_wd_nx;
  logic r_open, w_open_nx, r_abort, w_abort_nx, r_busy, w_busy_nx, r_fault, w_fault_nx;
  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0] w_rot;
  logic w_own_req;
  assign w_dbl     = {i_req, i_req} >> r_ptr;
  assign w_rot     = w_dbl[N_REQ-1:0];
  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_pick    = (w_sum >= IW1'(N_REQ)) ? IW'(w_sum - IW1'(N_REQ)) : IW'(w_sum);
  assign w_own_inc = (r_own == IW'(N_REQ - 1)) ? '0 : r_own + 1'b1;
  assign w_own_req = |(i_req & r_gnt);
  // first requester at or after the round-robin pointer, and its repeat count
  always_comb begin
    w_off   = '0;
    w_slice = '0;
    for (int k = N_REQ - 1; k >= 0; k--) w_off = w_rot[k] ? IW'(k) : w_off;
    for (int k = 0; k < N_REQ; k++) w_slice = (IW'(k) == w_pick) ? i_reps[k*RW +: RW] : w_slice;
  end
  // next state and next registered outputs; abort outranks expiry, expiry outranks watchdog
  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_own_nx   = r_own;
    w_ptr_nx   = r_ptr;
    w_rep_nx   = r_rep;
    w_wd_nx    = r_wd;
    w_open_nx  = 1'b0;
    w_done_nx  = '0;
    w_abort_nx = 1'b0;
    w_fault_nx = r_fault;
    case (r_state)
      IDLE: if (|i_req) begin
        w_state_nx = RUN;
        w_gnt_nx   = N_REQ'(1) << w_pick;
        w_own_nx   = w_pick;
        w_rep_nx   = (w_slice == '0) ? RW'(1) : w_slice;
        w_wd_nx    = '0;
        w_open_nx  = 1'b1;
      end
      RUN, RELOAD: if (!w_own_req) begin
        w_state_nx = IDLE;
        w_gnt_nx   = '0;
        w_abort_nx = 1'b1;
        w_ptr_nx   = w_own_inc;
      end else if (r_state == RELOAD) begin
        w_state_nx = RUN;
        w_wd_nx    = '0;
        w_open_nx  = 1'b1;
      end else if (i_tmr_expired && r_rep <= RW'(1)) begin
        w_state_nx = DONE;
        w_gnt_nx   = '0;
        w_done_nx  = r_gnt;
        w_ptr_nx   = w_own_inc;
      end else if (i_tmr_expired) begin
        w_state_nx = RELOAD;
        w_rep_nx   = r_rep - 1'b1;
      end else if (r_wd == WD_LAST) begin
        w_state_nx = IDLE;
        w_gnt_nx   = '0;
        w_fault_nx = 1'b1;
      end else begin
        w_wd_nx    = r_wd + 1'b1;
        w_open_nx  = 1'b1;
      end
      default: w_state_nx = IDLE;
    endcase
    w_busy_nx = (w_state_nx == RUN) || (w_state_nx == RELOAD);
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_state_nx;
  // datapath and output registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_gnt   <= '0;
      r_done  <= '0;
      r_own   <= '0;
      r_ptr   <= '0;
      r_rep   <= '0;
      r_wd    <= '0;
      r_open  <= 1'b0;
      r_abort <= 1'b0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_gnt   <= w_gnt_nx;
      r_done  <= w_done_nx;
      r_own   <= w_own_nx;
      r_ptr   <= w_ptr_nx;
      r_rep   <= w_rep_nx;
      r_wd    <= w_wd_nx;
      r_open  <= w_open_nx;
      r_abort <= w_abort_nx;
      r_busy  <= w_busy_nx;
      r_fault <= w_fault_nx;
    end
  assign o_tmr_open = r_open;
  assign o_gnt      = r_gnt;
  assign o_done     = r_done;
  assign o_aborted  = r_abort;
  assign o_busy     = r_busy;
  assign o_fault    = r_fault;
endmodule

// File: tb/tb_dingshi_sched.sv
// tb_dingshi_sched: randomized transaction-level check of the shared-timer scheduler
module tb_dingshi_sched;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] req = '0;
  logic [15:0] reps = '0;
  logic tmr_expired, o_tmr_open, o_aborted, o_busy, o_fault;
  logic [3:0] o_gnt, o_done;
  logic [2:0] tcnt = '0;
  bit tmr_en = 1'b1;
  int vec = 0, err = 0, m_ptr = 0;

  dingshi_sched #(.N_REQ(4), .RW(4), .WD_MAX(16)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_reps(reps), .i_tmr_expired(tmr_expired),
    .o_tmr_open(o_tmr_open), .o_gnt(o_gnt), .o_done(o_done), .o_aborted(o_aborted),
    .o_busy(o_busy), .o_fault(o_fault));

  always #5 clk = ~clk;

  // timer model: expires 4 cycles after open rises, reloaded whenever open is low
  always @(posedge clk) tcnt <= !o_tmr_open ? 3'd0 : (tcnt < 3'd4 ? tcnt + 3'd1 : tcnt);
  assign tmr_expired = tmr_en && o_tmr_open && tcnt == 3'd4;

  function automatic int pick(input logic [3:0] r);
    for (int k = 0; k < 4; k++) if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return 0;
  endfunction

  task automatic run_txn(input logic [3:0] r, input logic [15:0] rp, input int lat);
    int g, n, ex, gp, c;
    logic [3:0] oh;
    req = r; reps = rp;
    g = pick(r); n = int'(rp[g*4 +: 4]); if (n == 0) n = 1;
    oh = 4'(1 << g);
    c = 0;
    do begin @(negedge clk); c++; end while (o_gnt == '0 && c < 10);
    vec++;
    if (c !== lat || o_gnt !== oh || o_tmr_open !== 1'b1 || o_busy !== 1'b1) begin
      err++; $display("FAIL grant: lat=%0d gnt=%b open=%b busy=%b, expected lat=%0d gnt=%b open=1 busy=1", c, o_gnt, o_tmr_open, o_busy, lat, oh);
    end
    ex = 0; gp = 0; c = 0;
    while (o_done == '0 && c < 500) begin
      if (tmr_expired) ex++;
      if (o_busy && !o_tmr_open) gp++;
      @(negedge clk); c++;
    end
    vec++;
    if (o_done !== oh || o_gnt !== '0 || o_tmr_open !== 1'b0 || o_busy !== 1'b0 || o_aborted !== 1'b0 || ex != n || gp != n - 1) begin
      err++; $display("FAIL done: done=%b gnt=%b open=%b busy=%b ab=%b periods=%0d gaps=%0d, expected done=%b periods=%0d gaps=%0d", o_done, o_gnt, o_tmr_open, o_busy, o_aborted, ex, gp, oh, n, n - 1);
    end
    m_ptr = (g + 1) % 4;
  endtask

  task automatic idle();
    req = '0;
    @(negedge clk);
    vec++;
    if (o_done !== '0 || o_busy !== 1'b0 || o_gnt !== '0 || o_aborted !== 1'b0) begin
      err++; $display("FAIL idle: done=%b busy=%b gnt=%b ab=%b, expected all 0", o_done, o_busy, o_gnt, o_aborted);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vec++;
    if ({o_tmr_open, o_gnt, o_done, o_aborted, o_busy, o_fault} !== '0) begin
      err++; $display("FAIL reset: outputs=%b, expected 0", {o_tmr_open, o_gnt, o_done, o_aborted, o_busy, o_fault});
    end
    rst = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_round_robin();
    run_txn(4'b1111, 16'h1111, 1);
    for (int i = 0; i < 4; i++) run_txn(4'b1111, 16'h1111, 2);
    idle();
  endtask

  task automatic test_single();
    run_txn(4'b0001, 16'h0003, 1);
    idle();
  endtask

  task automatic test_zero_reps();
    run_txn(4'b0100, 16'hF0FF, 1);
    idle();
  endtask

  task automatic test_abort();
    int c;
    req = 4'b0010; reps = 16'h0050;
    c = 0;
    do begin @(negedge clk); c++; end while (o_gnt == '0 && c < 10);
    c = 0;
    while (!tmr_expired && c < 20) begin @(negedge clk); c++; end
    vec++;
    if (!tmr_expired || o_gnt !== 4'b0010) begin
      err++; $display("FAIL abort_first_period: expired=%b gnt=%b, expected 1 and 0010", tmr_expired, o_gnt);
    end
    repeat (3) @(negedge clk);
    req = '0;
    @(negedge clk);
    vec++;
    if (o_aborted !== 1'b1 || o_gnt !== '0 || o_tmr_open !== 1'b0 || o_busy !== 1'b0 || o_done !== '0) begin
      err++; $display("FAIL abort: ab=%b gnt=%b open=%b busy=%b done=%b, expected ab=1 rest 0", o_aborted, o_gnt, o_tmr_open, o_busy, o_done);
    end
    @(negedge clk);
    vec++;
    if (o_aborted !== 1'b0 || o_done !== '0) begin
      err++; $display("FAIL abort_pulse: ab=%b done=%b, expected 0 0", o_aborted, o_done);
    end
    m_ptr = 2;
    run_txn(4'b1111, 16'h1111, 1);
    idle();
  endtask

  task automatic test_random();
    int lat;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1 || i == 0) begin idle(); lat = 1; end
      else lat = 2;
      run_txn(4'($urandom_range(1, 15)), 16'($urandom), lat);
    end
    idle();
  endtask

  task automatic test_watchdog();
    req = 4'b0001; tmr_en = 1'b0;
    @(negedge clk);
    repeat (15) @(negedge clk);
    vec++;
    if (o_fault !== 1'b0 || o_gnt !== 4'b0001) begin
      err++; $display("FAIL wd_early: fault=%b gnt=%b, expected 0 0001", o_fault, o_gnt);
    end
    @(negedge clk);
    vec++;
    if (o_fault !== 1'b1 || o_gnt !== '0 || o_tmr_open !== 1'b0 || o_busy !== 1'b0 || o_done !== '0) begin
      err++; $display("FAIL wd_fault: fault=%b gnt=%b open=%b busy=%b done=%b, expected fault=1 rest 0", o_fault, o_gnt, o_tmr_open, o_busy, o_done);
    end
    tmr_en = 1'b1;
    run_txn(4'b0001, 16'h0002, 1);
    vec++;
    if (o_fault !== 1'b1) begin
      err++; $display("FAIL wd_sticky: fault=%b, expected 1", o_fault);
    end
    idle();
  endtask

  task automatic test_reset_mid_run();
    int c;
    req = 4'b1000; reps = 16'h5000;
    c = 0;
    do begin @(negedge clk); c++; end while (o_gnt == '0 && c < 10);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    vec++;
    if ({o_tmr_open, o_gnt, o_done, o_aborted, o_busy, o_fault} !== '0) begin
      err++; $display("FAIL reset_async: outputs=%b, expected 0", {o_tmr_open, o_gnt, o_done, o_aborted, o_busy, o_fault});
    end
    req = 4'b1111;
    @(negedge clk);
    rst = 1'b1;
    m_ptr = 0;
    run_txn(4'b1111, 16'h2222, 1);
    idle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_reps();
    test_abort();
    test_random();
    test_watchdog();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
